decoder3to8_strobe: RTL
=======================

# decoder3to8_strobe

Sequenced 3-to-8 decoder. Accepts 3-bit codes over a valid/ready handshake and drives the matching one-hot line of an 8-bit strobe bus for a fixed number of cycles, then holds the bus idle for a fixed gap. Each strobe is counted. It sits on the consumer side of the design's 3-bit index encoding and turns indices back into timed one-hot select/enable pulses for downstream logic.

## Interface

Parameters:
- HOLD, 4: cycles each strobe line stays asserted. Legal range 1..255.
- GAP, 1: extra all-zero cycles after each strobe before the next code can be accepted. Legal range 0..255.
- CNT_W, 8: width of the completed-strobe counter.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  accept enable. When low, no new codes are accepted; a strobe already in progress still completes.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  3  binary index 0..7 of the line to strobe.
- in_ready  output  1  block can accept a code this cycle.
- out  output  8  registered one-hot strobe bus. All zero when not strobing.
- busy  output  1  high in DRIVE and GAP states.
- done  output  1  one-cycle pulse when a strobe finishes.
- count  output  CNT_W  number of completed strobes, modulo 2^CNT_W.

## Operation

- FSM states: IDLE, DRIVE, GAP. An internal 8-bit down-counter, timer, sets the length of DRIVE and GAP.
- Combinational ready: in_ready = (state == IDLE) && en && !rst.
- Accept rule: a code is accepted on a rising edge where in_valid && in_ready.
- IDLE:
  - out = 0.
  - On accept: out <= 1 << in_code, timer <= HOLD-1, state <= DRIVE.
  - Without accept: stay in IDLE.
- DRIVE:
  - out holds its value.
  - If timer != 0: timer decrements.
  - If timer == 0: out <= 0, done <= 1, count <= count+1.
  - Then, if GAP > 0: timer <= GAP-1 and state <= GAP. Otherwise state <= IDLE.
- GAP:
  - out = 0.
  - If timer != 0: timer decrements.
  - If timer == 0: state <= IDLE.
- done:
  - Registered and high for exactly one cycle per strobe.
  - It is high in the same cycle that out first returns to zero.
  - Cleared on every other edge.
- count:
  - Wraps from 2^CNT_W-1 to 0.
  - Increments only on strobe completion, never on accept.
- en:
  - Sampled only through in_ready.
  - Deasserting en during DRIVE or GAP does not shorten or abort the sequence.
- in_valid while not ready: the code is ignored and not queued. The producer must hold in_valid and in_code until accepted.
- Every in_code value 0..7 is legal. There is no error case.
- The out bus is always one-hot or all-zero, never multi-hot.

## Timing

- Reset (asynchronous assert, synchronous-safe release):
  - state = IDLE, out = 0, done = 0, busy = 0, count = 0, timer = 0.
  - in_ready = 0 while rst is high. After release, in_ready = en.
- Accept edge E:
  - out is one-hot for exactly HOLD cycles, from edge E to edge E+HOLD.
  - At edge E+HOLD: out = 0, done = 1, count is updated.
- busy is high from edge E to edge E+HOLD+GAP.
- in_ready is high again in the cycle after edge E+HOLD+GAP. The earliest next accept is edge E+HOLD+GAP+1.
- Back-to-back period is HOLD+GAP+1 cycles. out is zero for GAP+1 cycles between strobes.
- Reset mid-strobe: out, done and busy clear immediately and asynchronously. count returns to 0. The interrupted strobe is not counted.

## Test plan

- Reset then single code, HOLD=4, GAP=1, en=1, in_code=5 accepted at edge E:
  - out = 8'b00100000 for 4 cycles.
  - At E+4: out = 0, done pulses once, count = 1.
  - in_ready is high again after E+5.
- Sweep of all 8 codes back-to-back, in_valid held high:
  - Each line strobes in order 0..7 with a period of 6 cycles.
  - out is never multi-hot.
  - count = 8.
- HOLD=1, GAP=0, continuous valid:
  - out alternates one-hot and zero every cycle.
  - done pulses every 2nd cycle.
  - in_ready is high only in the zero cycles.
- en dropped 2 cycles into a strobe:
  - The strobe completes its full HOLD and done pulses.
  - in_ready stays low while en = 0 and a valid code is held pending.
  - Raising en causes the pending code to be accepted on the next edge.
- Counter wrap with CNT_W=2: after 5 strobes, count = 1.
- Async reset asserted mid-DRIVE (code 3):
  - out = 0, busy = 0, count = 0 immediately, with no done pulse.
  - After release, the next accept strobes normally.

Source files
------------

// File: rtl/decoder3to8_strobe.sv
// Sequenced 3-to-8 decoder: accepts a 3-bit code over valid/ready, drives the matching
// one-hot strobe line for HOLD cycles, idles the bus for GAP cycles, and counts strobes.
module decoder3to8_strobe #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_timer;
  logic [7:0]       r_out;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_timer_zero;

  assign w_accept     = in_valid && in_ready;
  assign w_timer_zero = (r_timer == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_DRIVE;
      ST_DRIVE: if (w_timer_zero) w_next = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (w_timer_zero) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      ST_IDLE:  in_ready = en && !rst;
      ST_DRIVE: busy     = 1'b1;
      ST_GAP:   busy     = 1'b1;
      default:  busy     = 1'b0;
    endcase
  end

  // Timer, strobe bus, completion pulse and counter; done defaults low every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 8'd0;
      r_out   <= 8'd0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_out   <= 8'd1 << in_code;
            r_timer <= HOLD_M1;
          end
        end
        ST_DRIVE: begin
          if (!w_timer_zero) begin
            r_timer <= r_timer - 8'd1;
          end else begin
            r_out   <= 8'd0;
            r_done  <= 1'b1;
            r_count <= r_count + CNT_W'(1);
            r_timer <= GAP_M1;
          end
        end
        ST_GAP: begin
          if (!w_timer_zero) r_timer <= r_timer - 8'd1;
        end
        default: begin
          r_out   <= 8'd0;
          r_timer <= 8'd0;
        end
      endcase
    end
  end

  assign out   = r_out;
  assign done  = r_done;
  assign count = r_count;

endmodule
